// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// ARB_RR_EN selects round-robin arbitration instead of LS priority with a streak guard.
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  input  logic            ls_req,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_we,
  input  logic [DW/8-1:0] ls_be,
  input  logic [DW-1:0]   ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   rdata,
  output logic            sel,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0] state;
  logic       arb;
  logic       win_ls;
  logic       win_if;
  logic       resp;

  assign arb    = (state == IDLE) & (if_req | ls_req);
  assign win_if = if_req & ~win_ls;

`ifdef ARB_RR_EN
  logic last_ls;

  assign win_ls = ls_req & (~if_req | ~last_ls);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ls <= 1'b1;
    end else if (arb) begin
      last_ls <= win_ls;
    end
  end
`else
  localparam int SW = $clog2(MAX_LS_STREAK + 1);

  logic [SW-1:0] streak;

  assign win_ls = ls_req &
    (~if_req | (streak != SW'(MAX_LS_STREAK)));

  // streak only counts LS wins that kept a pending IF waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (!if_req) begin
      streak <= '0;
    end else if (arb && win_if) begin
      streak <= '0;
    end else if (arb && win_ls) begin
      streak <= streak + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt <= 1'b0;
      ls_gnt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb) begin
            state  <= REQ;
            sel    <= win_ls;
            if_gnt <= win_if;
            ls_gnt <= win_ls;
            if (win_ls) begin
              mem_addr  <= ls_addr;
              mem_we    <= ls_we;
              mem_be    <= ls_be;
              mem_wdata <= ls_wdata;
            end else begin
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
              mem_be    <= '1;
              mem_wdata <= '0;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            state <= mem_rvalid ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a response in the accept cycle is taken as accept plus response
  assign resp = mem_rvalid &
    ((state == WAIT) | ((state == REQ) & mem_ready));

  assign mem_req   = (state == REQ);
  assign if_rvalid = resp & ~sel;
  assign ls_rvalid = resp & sel;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Grant and response expectations are queued; a monitor pops and compares.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] rdata;
  logic        sel;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_be(ls_be),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .rdata(rdata),
    .sel(sel), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ls;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct {
    bit          ls;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    gcyc[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    gcount = 0;
  int    hold = 0;
  int    lat = 1;
  int    cnt = 0;
  logic [31:0] pdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic gexp_t g_if(input logic [31:0] a);
    gexp_t g;
    g.ls = 0; g.addr = a; g.we = 0; g.be = 4'hF; g.wdata = '0;
    return g;
  endfunction

  function automatic gexp_t g_ls(input logic [31:0] a,
                                 input bit w,
                                 input logic [3:0] b,
                                 input logic [31:0] d);
    gexp_t g;
    g.ls = 1; g.addr = a; g.we = w; g.be = b; g.wdata = d;
    return g;
  endfunction

  function automatic rexp_t r_of(input bit l, input logic [31:0] d);
    rexp_t r;
    r.ls = l; r.data = d;
    return r;
  endfunction

  // memory model: optional ready stall, response latency lat (0 = same cycle)
  initial begin
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1; mem_rdata = pdata;
        end
      end
      if (mem_req) begin
        if (hold > 0) hold--;
        else begin
          mem_ready = 1;
          if (lat == 0) begin
            mem_rvalid = 1; mem_rdata = mdata(mem_addr);
          end else begin
            cnt = lat; pdata = mdata(mem_addr);
          end
        end
      end
    end
  end

  // monitor
  initial begin
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (if_gnt || ls_gnt) begin
        gcount++;
        gcyc.push_back(cyc);
        chk("gnt_onehot", {63'd0, if_gnt & ls_gnt}, 0);
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_unexpected: got if=%0b ls=%0b expected none",
                   if_gnt, ls_gnt);
        end else begin
          g = gq.pop_front();
          chk("gnt_who", {63'd0, ls_gnt}, {63'd0, g.ls});
          chk("gnt_sel", {63'd0, sel}, {63'd0, g.ls});
          chk("gnt_mem_req", {63'd0, mem_req}, 1);
          chk("gnt_addr", {32'd0, mem_addr}, {32'd0, g.addr});
          chk("gnt_we", {63'd0, mem_we}, {63'd0, g.we});
          chk("gnt_be", {60'd0, mem_be}, {60'd0, g.be});
          if (g.we) chk("gnt_wdata", {32'd0, mem_wdata}, {32'd0, g.wdata});
        end
      end
      if (if_rvalid || ls_rvalid) begin
        chk("rv_onehot", {63'd0, if_rvalid & ls_rvalid}, 0);
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rv_unexpected: got if=%0b ls=%0b expected none",
                   if_rvalid, ls_rvalid);
        end else begin
          r = rq.pop_front();
          chk("rv_who", {63'd0, ls_rvalid}, {63'd0, r.ls});
          chk("rv_data", {32'd0, rdata}, {32'd0, r.data});
        end
      end
    end
  end

  task automatic wait_gnt(input bit ls, output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      if (ls ? ls_gnt : if_gnt) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: got no gnt expected gnt ls=%0b", ls);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (gq.size() == 0 && rq.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_gq", gq.size(), 0);
    chk("drain_rq", rq.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_sel", {63'd0, sel}, 0);
    chk("rst_mem_req", {63'd0, mem_req}, 0);
    chk("rst_mem_we", {63'd0, mem_we}, 0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 0);
    chk("rst_mem_be", {60'd0, mem_be}, 0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 0);
    chk("rst_gnt", {62'd0, if_gnt, ls_gnt}, 0);
    chk("rst_rvalid", {62'd0, if_rvalid, ls_rvalid}, 0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #3 rst = 1;
    @(negedge clk);
    #3 rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    int c0;
    int base;
    logic [31:0] a0;
    logic s0;
    rst = 1; if_req = 0; if_addr = '0;
    ls_req = 0; ls_addr = '0; ls_we = 0;
    ls_be = '0; ls_wdata = '0;
    @(negedge clk);
    #2;
    chk_reset_vals();
    rst = 0;

    // single IF read
    gq.push_back(g_if(32'h100));
    rq.push_back(r_of(0, 32'hDEADBEEF));
    @(negedge clk);
    #3;
    if_req = 1; if_addr = 32'h100; c0 = cyc;
    wait_gnt(0, ok);
    if_req = 0;
    chk("gnt_latency", cyc - c0, 1);
    drain();
    chk("sel_idle_if", {63'd0, sel}, 0);

    // continuous contention
    pulse_rst();
`ifdef ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      gq.push_back(g_if(32'h300));
      rq.push_back(r_of(0, 32'h5A5A_0300));
      gq.push_back(g_ls(32'h200, 1, 4'b0011, 32'h1122_3344));
      rq.push_back(r_of(1, 32'h5A5A_0200));
    end
`else
    for (int i = 0; i < 4; i++) begin
      gq.push_back(g_ls(32'h200, 1, 4'b0011, 32'h1122_3344));
      rq.push_back(r_of(1, 32'h5A5A_0200));
    end
    gq.push_back(g_if(32'h300));
    rq.push_back(r_of(0, 32'h5A5A_0300));
    gq.push_back(g_ls(32'h200, 1, 4'b0011, 32'h1122_3344));
    rq.push_back(r_of(1, 32'h5A5A_0200));
`endif
    base = gcyc.size();
    c0 = gcount;
    @(negedge clk);
    #3;
    if_req = 1; if_addr = 32'h300;
    ls_req = 1; ls_addr = 32'h200; ls_we = 1;
    ls_be = 4'b0011; ls_wdata = 32'h1122_3344;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #3;
      if (gcount - c0 >= 6) break;
    end
    if_req = 0; ls_req = 0;
    chk("contend_grants", gcount - c0, 6);
    for (int i = 1; i < 6; i++)
      if (base + i < gcyc.size())
        chk("turnaround3", gcyc[base+i] - gcyc[base+i-1], 3);
    drain();

    // ready stall in REQ
    gq.push_back(g_ls(32'h400, 0, 4'b1111, 32'h0));
    rq.push_back(r_of(1, 32'h5A5A_0400));
    hold = 5;
    @(negedge clk);
    #3;
    ls_req = 1; ls_addr = 32'h400; ls_we = 0; ls_be = 4'b1111;
    wait_gnt(1, ok);
    ls_req = 0;
    a0 = mem_addr; s0 = sel;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      chk("stall_req", {63'd0, mem_req}, 1);
      chk("stall_addr", {32'd0, mem_addr}, {32'd0, a0});
      chk("stall_sel", {63'd0, sel}, {63'd0, s0});
      chk("stall_nognt", {62'd0, if_gnt, ls_gnt}, 0);
    end
    drain();
    chk("sel_idle_ls", {63'd0, sel}, 1);
    chk("idle_mem_req", {63'd0, mem_req}, 0);

    // accept and response in the same REQ cycle
    lat = 0;
`ifdef ARB_RR_EN
    gq.push_back(g_if(32'h600));
    rq.push_back(r_of(0, 32'h5A5A_0600));
    gq.push_back(g_ls(32'h500, 1, 4'b0011, 32'h1122_3344));
    rq.push_back(r_of(1, 32'h5A5A_0500));
`else
    gq.push_back(g_ls(32'h500, 1, 4'b0011, 32'h1122_3344));
    rq.push_back(r_of(1, 32'h5A5A_0500));
    gq.push_back(g_if(32'h600));
    rq.push_back(r_of(0, 32'h5A5A_0600));
`endif
    base = gcyc.size();
    @(negedge clk);
    #3;
    if_req = 1; if_addr = 32'h600;
    ls_req = 1; ls_addr = 32'h500; ls_we = 1;
    ls_be = 4'b0011; ls_wdata = 32'h1122_3344;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (if_gnt) if_req = 0;
      if (ls_gnt) ls_req = 0;
      if (!if_req && !ls_req) break;
    end
    if_req = 0; ls_req = 0;
    chk("same_grants", gcyc.size() - base, 2);
    if (gcyc.size() - base == 2)
      chk("same_turnaround", gcyc[base+1] - gcyc[base], 2);
    drain();

    // reset while waiting on an LS response
    lat = 4;
    gq.push_back(g_ls(32'h700, 0, 4'b1111, 32'h0));
    @(negedge clk);
    #3;
    ls_req = 1; ls_addr = 32'h700; ls_we = 0; ls_be = 4'b1111;
    wait_gnt(1, ok);
    ls_req = 0;
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    #3 rst = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #3;
      if (mem_rvalid) begin
        seen = 1;
        chk("stale_no_rvalid", {63'd0, ls_rvalid}, 0);
      end
    end
    chk("stale_seen", {63'd0, seen}, 1);
    lat = 1;
    gq.push_back(g_if(32'h100));
    rq.push_back(r_of(0, 32'hDEADBEEF));
    @(negedge clk);
    #3;
    if_req = 1; if_addr = 32'h100;
    wait_gnt(0, ok);
    if_req = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
